// File: rtl/clk_div_sequencer_if.sv
// Control/status bundle between the trigger-board control logic and the divider sequencer.
// Latency: none (wires only).
// Backpressure: none; requests are single-cycle pulses and status is level/pulse.
//
// Signals:
//   START/STOP/RESYNC : single-cycle requests into the sequencer
//   DIV_SEL           : which divided output is monitored (0=/2, 1=/4, 2,3=/8)
//   Q_MON             : divider outputs fed back ([0]=/2, [1]=/4, [2]=/8)
//   DIV_MR/DIV_EN_    : divider master reset and active-low enable
//   LOCKED/ERR/STATE  : lock level, one-cycle error pulse, sequencer state
interface clk_div_sequencer_if;
   logic       START;
   logic       STOP;
   logic       RESYNC;
   logic [1:0] DIV_SEL;
   logic [2:0] Q_MON;
   logic       DIV_MR;
   logic       DIV_EN_;
   logic       LOCKED;
   logic       ERR;
   logic [2:0] STATE;

   modport master (
      output START, STOP, RESYNC, DIV_SEL, Q_MON,
      input  DIV_MR, DIV_EN_, LOCKED, ERR, STATE
   );

   modport slave (
      input  START, STOP, RESYNC, DIV_SEL, Q_MON,
      output DIV_MR, DIV_EN_, LOCKED, ERR, STATE
   );
endinterface

// File: rtl/clk_div_sequencer.sv
// Start/stop/resync sequencer for the /2,/4,/8 ECL divider, plus toggle-spacing lock monitor.
// Latency: all outputs registered; a request sampled on edge N is reflected after edge N.
// Backpressure: none; requests are sampled every cycle with priority STOP > RESYNC > START.
//
// Ports: CLK (system clock, also clocks the divider), MR (synchronous active-high reset),
//        bus (slave side of clk_div_sequencer_if: requests, DIV_SEL, Q_MON in;
//             DIV_MR, DIV_EN_, LOCKED, ERR, STATE out).
module clk_div_sequencer #(
   parameter int RST_CYC    = 4,
   parameter int SETTLE_CYC = 3,
   parameter int LOCK_CNT   = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                 CLK,
   input  logic                 MR,
   clk_div_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RESET  = 3'd1,
      SETTLE = 3'd2,
      RUN    = 3'd3,
      FAULT  = 3'd4
   } state_t;

   localparam int IW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(LOCK_CNT + 1);

   localparam logic [3:0]    RST_LAST = 4'(RST_CYC - 1);
   localparam logic [3:0]    SET_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [IW-1:0] TO_LAST  = IW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);

   state_t        state, state_n;
   logic [3:0]    cnt, cnt_n;
   logic [IW-1:0] ivl, ivl_n;       // cycles since last edge, minus one at the next edge
   logic [GW-1:0] good, good_n;
   logic          seen, seen_n;     // first edge since (re)start already taken
   logic          locked_n, err_n;
   logic [2:0]    sync1, sync2;
   logic [1:0]    sel_q;
   logic [1:0]    idx;
   logic [IW-1:0] half_last;
   logic          mon_edge;
   logic          sel_chg;

   // All three feedback bits are synchronised so a DIV_SEL change switches
   // cleanly to an already-settled pipeline.
   assign idx      = (bus.DIV_SEL == 2'd3) ? 2'd2 : bus.DIV_SEL;
   assign mon_edge = sync1[idx] ^ sync2[idx];   // second flop changes on this edge
   assign sel_chg  = (bus.DIV_SEL != sel_q);
   assign bus.STATE = state;

   // Expected half-period minus one, matching the ivl value seen at an edge.
   always_comb begin
      half_last = IW'(3);
      case (idx)
         2'd0:    half_last = IW'(0);
         2'd1:    half_last = IW'(1);
         default: half_last = IW'(3);
      endcase
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      ivl_n    = ivl;
      good_n   = good;
      seen_n   = seen;
      locked_n = bus.LOCKED;
      err_n    = 1'b0;

      case (state)
         IDLE: begin
            if (bus.START && !bus.STOP) begin
               state_n = RESET;
               cnt_n   = '0;
            end
         end
         RESET: begin
            if (bus.STOP)                     state_n = IDLE;
            else if (bus.RESYNC || bus.START) cnt_n   = '0;
            else if (cnt == RST_LAST) begin
               state_n = SETTLE;
               cnt_n   = '0;
            end else                          cnt_n   = cnt + 4'd1;
         end
         SETTLE: begin
            if (bus.STOP) state_n = IDLE;
            else if (bus.RESYNC) begin
               state_n = RESET;
               cnt_n   = '0;
            end else if (cnt == SET_LAST) begin
               state_n = RUN;
               cnt_n   = '0;
            end else cnt_n = cnt + 4'd1;
         end
         RUN: begin
            if (bus.STOP) state_n = IDLE;
            else if (bus.RESYNC) begin
               state_n = RESET;
               cnt_n   = '0;
            end else if (sel_chg) begin
               // New source: forget history, next edge only starts timing.
               ivl_n    = '0;
               good_n   = '0;
               seen_n   = 1'b0;
               locked_n = 1'b0;
            end else begin
               // Lock asserts one cycle after the good count saturates.
               if (good == GOOD_MAX) locked_n = 1'b1;
               if (mon_edge) begin
                  ivl_n = '0;
                  if (!seen) seen_n = 1'b1;
                  else if (ivl == half_last) begin
                     if (good != GOOD_MAX) good_n = good + GW'(1);
                  end else begin
                     good_n   = '0;
                     locked_n = 1'b0;
                     err_n    = 1'b1;
                  end
               end else if (ivl == TO_LAST) begin
                  state_n = FAULT;
                  err_n   = 1'b1;
               end else begin
                  ivl_n = ivl + IW'(1);
               end
            end
         end
         FAULT: begin
            if (bus.STOP) state_n = IDLE;
            else if (bus.START || bus.RESYNC) begin
               state_n = RESET;
               cnt_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase

      // Monitor is idle and cleared outside RUN, so entry to RUN starts fresh.
      if (state_n != RUN) begin
         ivl_n    = '0;
         good_n   = '0;
         seen_n   = 1'b0;
         locked_n = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (MR) begin
         state       <= IDLE;
         cnt         <= '0;
         ivl         <= '0;
         good        <= '0;
         seen        <= 1'b0;
         sync1       <= '0;
         sync2       <= '0;
         sel_q       <= '0;
         bus.DIV_MR  <= 1'b1;
         bus.DIV_EN_ <= 1'b1;
         bus.LOCKED  <= 1'b0;
         bus.ERR     <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         ivl         <= ivl_n;
         good        <= good_n;
         seen        <= seen_n;
         sync1       <= bus.Q_MON;
         sync2       <= sync1;
         sel_q       <= bus.DIV_SEL;
         // Divider controls follow the next state so they move with STATE.
         bus.DIV_MR  <= (state_n == IDLE) || (state_n == RESET) || (state_n == FAULT);
         bus.DIV_EN_ <= (state_n != RUN);
         bus.LOCKED  <= locked_n;
         bus.ERR     <= err_n;
      end
   end

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Randomised bench for clk_div_sequencer with a timestamp-based reference model and scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_div_sequencer;

   localparam int RST_CYC    = 4;
   localparam int SETTLE_CYC = 3;
   localparam int LOCK_CNT   = 8;
   localparam int TIMEOUT    = 16;

   localparam int S_IDLE = 0, S_RESET = 1, S_SETTLE = 2, S_RUN = 3, S_FAULT = 4;

   typedef struct packed {
      int         cyc;
      logic [6:0] vec;   // {STATE, DIV_MR, DIV_EN_, LOCKED, ERR}
   } ev_t;

   logic CLK;
   logic MR;
   clk_div_sequencer_if bus();

   clk_div_sequencer dut (
      .CLK (CLK),
      .MR  (MR),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   ev_t  exp_q[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   // Divider stand-in: free-running binary counter gated by DIV_MR/DIV_EN_.
   logic [2:0] dcnt   = 3'd0;
   int         freeze = 0;
   bit         skip   = 1'b0;

   task automatic step(input bit s, input bit p, input bit r, input bit m);
      @(negedge CLK);
      bus.START  = s;
      bus.STOP   = p;
      bus.RESYNC = r;
      MR         = m;
      if (bus.DIV_MR === 1'b1) dcnt = 3'd0;
      else if (bus.DIV_EN_ === 1'b0 && freeze == 0) dcnt = dcnt + (skip ? 3'd2 : 3'd1);
      if (freeze > 0) freeze--;
      skip = 1'b0;
      bus.Q_MON = dcnt;
   endtask

   // Reference model: sequencing by elapsed-time stamps, monitor by edge timestamps.
   initial begin
      int st, t_ent, last, reached, good, idx, h;
      bit first_pend, e, selchg, err, m, have_prev;
      logic [2:0] qm1, qm2, q;
      logic [1:0] selp, sel;
      logic [6:0] vec, prev;
      st = S_IDLE; t_ent = 0; last = 0; reached = -1; good = 0;
      first_pend = 1'b1; qm1 = '0; qm2 = '0; selp = '0; have_prev = 1'b0; prev = '0;
      forever begin
         @(posedge CLK);
         cyc++;
         m   = MR;
         sel = bus.DIV_SEL;
         q   = bus.Q_MON;
         idx = (sel == 2'd3) ? 2 : int'(sel);
         h   = 1 << idx;
         e   = qm1[idx] ^ qm2[idx];
         selchg = (sel != selp);
         err = 1'b0;
         if (m) begin
            qm1 = '0; qm2 = '0; selp = '0;
            st = S_IDLE; reached = -1; good = 0;
         end else begin
            qm2 = qm1; qm1 = q; selp = sel;
            case (st)
               S_IDLE:
                  if (bus.START && !bus.STOP) begin st = S_RESET; t_ent = cyc; end
               S_RESET:
                  if (bus.STOP) st = S_IDLE;
                  else if (bus.RESYNC || bus.START) t_ent = cyc;
                  else if (cyc - t_ent == RST_CYC) begin st = S_SETTLE; t_ent = cyc; end
               S_SETTLE:
                  if (bus.STOP) st = S_IDLE;
                  else if (bus.RESYNC) begin st = S_RESET; t_ent = cyc; end
                  else if (cyc - t_ent == SETTLE_CYC) begin
                     st = S_RUN; last = cyc; first_pend = 1'b1; reached = -1; good = 0;
                  end
               S_RUN:
                  if (bus.STOP) st = S_IDLE;
                  else if (bus.RESYNC) begin st = S_RESET; t_ent = cyc; end
                  else if (selchg) begin
                     last = cyc; first_pend = 1'b1; reached = -1; good = 0;
                  end else if (e) begin
                     if (first_pend) first_pend = 1'b0;
                     else if (cyc - last == h) begin
                        if (good < LOCK_CNT) good++;
                        if (good == LOCK_CNT && reached < 0) reached = cyc;
                     end else begin
                        good = 0; reached = -1; err = 1'b1;
                     end
                     last = cyc;
                  end else if (cyc - last == TIMEOUT) begin
                     st = S_FAULT; err = 1'b1;
                  end
               default:
                  if (bus.STOP) st = S_IDLE;
                  else if (bus.START || bus.RESYNC) begin st = S_RESET; t_ent = cyc; end
            endcase
         end
         vec = {3'(st),
                (st == S_IDLE || st == S_RESET || st == S_FAULT),
                (st != S_RUN),
                (st == S_RUN && reached >= 0 && reached < cyc),
                err};
         if (!have_prev || vec != prev || err) exp_q.push_back('{cyc: cyc, vec: vec});
         have_prev = 1'b1;
         prev = vec;
      end
   end

   // Monitor: every change of the output vector (or any ERR cycle) is a DUT event.
   initial begin
      bit first;
      logic [6:0] vec, prev;
      ev_t ev;
      first = 1'b1;
      prev  = '0;
      forever begin
         @(posedge CLK);
         #1;
         vec = {bus.STATE, bus.DIV_MR, bus.DIV_EN_, bus.LOCKED, bus.ERR};
         if (first || vec !== prev || bus.ERR === 1'b1) begin
            first = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_event cyc=%0d got=%b expected no event", cyc, vec);
            end else begin
               ev = exp_q.pop_front();
               if (ev.cyc != cyc || ev.vec !== vec) begin
                  failures++;
                  $display("FAIL event cyc=%0d got=%b required cyc=%0d vec=%b",
                           cyc, vec, ev.cyc, ev.vec);
               end
            end
         end
         prev = vec;
      end
   end

   initial begin
      MR = 1'b1;
      bus.START = 1'b0; bus.STOP = 1'b0; bus.RESYNC = 1'b0;
      bus.DIV_SEL = 2'd1;
      bus.Q_MON = 3'd0;

      // Reset, then idle without requests.
      repeat (3) step(0, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0);

      // Start-up sequence and lock on /4.
      step(1, 0, 0, 0);
      repeat (40) step(0, 0, 0, 0);

      // Switch to /8, lock, inject a short interval, re-lock.
      bus.DIV_SEL = 2'd2;
      repeat (50) step(0, 0, 0, 0);
      skip = 1'b1;
      step(0, 0, 0, 0);
      repeat (60) step(0, 0, 0, 0);

      // Frozen feedback -> timeout fault, then resync back through RESET.
      freeze = 30;
      repeat (25) step(0, 0, 0, 0);
      freeze = 0;
      step(0, 0, 1, 0);
      repeat (40) step(0, 0, 0, 0);

      // STOP and RESYNC together while in SETTLE.
      step(0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (5) step(0, 0, 0, 0);
      step(0, 1, 1, 0);
      repeat (3) step(0, 0, 0, 0);

      // MR while running on /2.
      bus.DIV_SEL = 2'd0;
      step(1, 0, 0, 0);
      repeat (30) step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0);

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         bit s, p, r, m;
         s = ($urandom_range(0, 99) < 3);
         p = ($urandom_range(0, 99) < 1);
         r = ($urandom_range(0, 99) < 1);
         m = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 99) < 2) bus.DIV_SEL = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) < 3) skip = 1'b1;
         if (freeze == 0 && $urandom_range(0, 99) < 2) freeze = $urandom_range(1, 24);
         step(s, p, r, m);
      end

      freeze = 0;
      repeat (5) step(0, 0, 0, 0);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_events got=0 required=%0d pending", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_div_sequencer.md
Name: clk_div_sequencer

Overview:
- Control stage directly upstream of the /2,/4,/8 ECL clock divider.
- Generates the divider's master-reset and active-low enable with a defined start/stop/resync sequence.
- Monitors one fed-back divided output for correct toggle spacing and reports lock or fault to the trigger-board control logic.
- Runs entirely in the input clock domain, the same clock that drives the divider.

Parameters:
- RST_CYC, 4, cycles DIV_MR is held high in the RESET state (1..15).
- SETTLE_CYC, 3, cycles between DIV_MR release and DIV_EN_ assertion (1..15).
- LOCK_CNT, 8, consecutive correct intervals required before LOCKED is asserted (1..255).
- TIMEOUT, 16, cycles without a monitored toggle before a fault is declared (must exceed 2×max half-period = 8).

Ports:
- CLK  in  1  system clock; also clocks the divider.
- MR  in  1  synchronous active-high reset for this block.
- START  in  1  single-cycle request to start the divider.
- STOP  in  1  single-cycle request to stop the divider.
- RESYNC  in  1  single-cycle request to re-phase the divider.
- DIV_SEL  in  2  monitored output select: 0 = /2, 1 = /4, 2 = /8, 3 = reserved (treated as /8).
- Q_MON  in  3  divider outputs fed back: [0] = /2, [1] = /4, [2] = /8.
- DIV_MR  out  1  reset to the divider.
- DIV_EN_  out  1  active-low enable to the divider.
- LOCKED  out  1  monitored output has a correct period.
- ERR  out  1  one-cycle pulse on a bad interval or timeout.
- STATE  out  3  current state encoding: IDLE = 0, RESET = 1, SETTLE = 2, RUN = 3, FAULT = 4.

Behaviour:
- All logic updates on rising CLK; MR is sampled synchronously.
- MR = 1 forces, on the next edge: STATE = IDLE, DIV_MR = 1, DIV_EN_ = 1, LOCKED = 0, ERR = 0, all counters = 0, synchroniser flops = 0.
- MR overrides everything, including mid-sequence.
- Request priority in any state: STOP > RESYNC > START.
- IDLE:
  - DIV_MR = 1, DIV_EN_ = 1.
  - START → RESET; RESYNC is ignored.
- RESET:
  - DIV_MR = 1, DIV_EN_ = 1.
  - Counts RST_CYC cycles, then → SETTLE.
  - STOP → IDLE. START/RESYNC restart the count.
- SETTLE:
  - DIV_MR = 0, DIV_EN_ = 1.
  - Counts SETTLE_CYC cycles, then → RUN.
  - STOP → IDLE. RESYNC → RESET.
- RUN:
  - DIV_MR = 0, DIV_EN_ = 0.
  - STOP → IDLE. RESYNC → RESET.
  - START is ignored.
- FAULT:
  - DIV_MR = 1, DIV_EN_ = 1, LOCKED = 0.
  - START or RESYNC → RESET. STOP → IDLE.
- Monitor (active in RUN only; the monitor's counters are cleared on entering RUN):
  - The selected Q_MON bit passes through a 2-flop synchroniser. An edge is any change of the second flop.
  - The expected half-period H is 1, 2 or 4 cycles for /2, /4, /8.
  - An interval counter counts cycles since the last edge.
  - The first edge after entering RUN only starts timing; it is not checked.
  - On each later edge:
    - If the interval equals H, the good count increments, saturating at LOCK_CNT.
    - Otherwise the good count is cleared, LOCKED = 0, and ERR pulses for one cycle.
  - LOCKED = 1 on the cycle after the good count reaches LOCK_CNT. It stays set until a bad interval, a state exit, or MR.
  - If the interval counter reaches TIMEOUT with no edge: ERR pulses, the block enters FAULT, and LOCKED = 0.
  - A DIV_SEL change during RUN clears the good count and LOCKED and restarts the first-edge rule. It generates no ERR.
- Outputs are registered.
- DIV_MR/DIV_EN_ change on the edge on which STATE changes. There is no combinational path from inputs to outputs.
- Entry to IDLE from any state clears LOCKED.

Test Plan:
- MR held 3 cycles, then released → STATE = 0, DIV_MR = 1, DIV_EN_ = 1, LOCKED = 0 until START.
- START pulse with defaults → STATE 1 for 4 cycles, then 2 for 3 cycles, then 3. DIV_EN_ falls 7 cycles after the START-sampled edge.
- RUN with DIV_SEL = 1, model divider toggling Q_MON[1] every 2 cycles → LOCKED rises after 8 good intervals following the first edge. ERR stays 0.
- RUN with DIV_SEL = 2, inject one 3-cycle interval after lock → single ERR pulse, LOCKED drops, then re-locks after 8 good intervals.
- Q_MON frozen in RUN → ERR pulse and STATE = 4 exactly 16 cycles after the last edge. DIV_MR = 1. A following RESYNC → STATE = 1.
- STOP and RESYNC asserted on the same cycle in SETTLE → IDLE. MR asserted in RUN → IDLE on the next edge, DIV_EN_ = 1.
